// File: rtl/parallel_link_controller.sv
// Host-facing controller for the shared 8-bit parallel port: synchronises the host
// strobe/direction, owns the pin driver and answers each strobe with one acknowledged byte.
module parallel_link_controller #(
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 4,
    parameter int RX_DEPTH     = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        chip_select,
    input  logic                        host_strobe,
    output logic                        host_ack,
    inout  wire  [7:0]                  data_pins,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic                        host_abort
);

    // state      | meaning
    // IDLE       | waiting for a fresh strobe rise
    // WR_CAPTURE | host writing; push pin byte once the FIFO has room
    // WR_ACK     | write acknowledged, waiting for strobe release
    // RD_WAIT    | host reading; waiting for a TX byte
    // RD_SETUP   | pins driven, counting setup time before ack
    // RD_ACK     | read acknowledged, pins held until strobe release
    typedef enum logic [2:0] {
        IDLE, WR_CAPTURE, WR_ACK, RD_WAIT, RD_SETUP, RD_ACK
    } state_t;

    localparam int AW = $clog2(RX_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] cs_sync_q, stb_sync_q;
    logic                   stb_prev_q;
    logic                   s_cs, s_stb, stb_rise;

    state_t          state_q, state_d;
    logic            host_ack_q, host_ack_d;
    logic            drive_en_q, drive_en_d;
    logic [7:0]      tx_hold_q, tx_hold_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            abort_q, abort_d;

    logic [7:0]      mem_q [RX_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic            push, pop, full;

    assign s_cs     = cs_sync_q[SYNC_STAGES-1];
    assign s_stb    = stb_sync_q[SYNC_STAGES-1];
    assign stb_rise = s_stb && !stb_prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync_q  <= '0;
            stb_sync_q <= '0;
            stb_prev_q <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], chip_select};
            stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], host_strobe};
            stb_prev_q <= s_stb;
        end
    end

    // Raw chip_select gates the driver so a direction flip releases the bus at once.
    assign data_pins = (drive_en_q && !chip_select) ? tx_hold_q : 8'bz;

    assign full     = (level_q == LW'(RX_DEPTH));
    assign rx_valid = (level_q != '0);
    assign pop      = rx_valid && rx_ready;
    assign rx_data  = mem_q[rd_ptr_q];
    assign rx_level = level_q;
    assign level_d  = level_q + LW'(push) - LW'(pop);

    assign tx_ready   = (state_q == RD_WAIT) && s_stb;
    assign host_ack   = host_ack_q;
    assign host_abort = abort_q;

    always_comb begin
        state_d    = state_q;
        host_ack_d = host_ack_q;
        drive_en_d = drive_en_q;
        tx_hold_d  = tx_hold_q;
        cnt_d      = cnt_q;
        abort_d    = 1'b0;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (stb_rise) state_d = s_cs ? WR_CAPTURE : RD_WAIT;
            end
            WR_CAPTURE: begin
                if (!s_stb) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (!full) begin
                    push       = 1'b1;
                    host_ack_d = 1'b1;
                    state_d    = WR_ACK;
                end
            end
            WR_ACK: begin
                if (!s_stb) begin
                    host_ack_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            RD_WAIT: begin
                if (!s_stb) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (tx_valid) begin
                    tx_hold_d  = tx_data;
                    drive_en_d = 1'b1;
                    cnt_d      = CW'(SETUP_CYCLES - 1);
                    state_d    = RD_SETUP;
                end
            end
            RD_SETUP: begin
                // Strobe loss during setup is treated as an abort so ack never rises unasked.
                if (!s_stb) begin
                    drive_en_d = 1'b0;
                    abort_d    = 1'b1;
                    state_d    = IDLE;
                end else if (cnt_q == '0) begin
                    host_ack_d = 1'b1;
                    state_d    = RD_ACK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RD_ACK: begin
                if (!s_stb) begin
                    host_ack_d = 1'b0;
                    drive_en_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            host_ack_q <= 1'b0;
            drive_en_q <= 1'b0;
            tx_hold_q  <= '0;
            cnt_q      <= '0;
            abort_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            host_ack_q <= host_ack_d;
            drive_en_q <= drive_en_d;
            tx_hold_q  <= tx_hold_d;
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
            level_q    <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= data_pins;
    end

endmodule

// File: doc/parallel_link_controller.md
Name: parallel_link_controller

Overview:
- Sequences the 8-bit bidirectional parallel port shared between the Raspberry Pi host and the DE0-Nano.
- The host drives the direction on chip_select and a strobe; this block answers each strobe with an acknowledge.
- For each strobe it either captures a byte into an RX FIFO or drives a byte taken from the internal TX stream.
- It owns the pin tristate control and the full handshake, so the fabric sees only valid/ready streams.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on chip_select and host_strobe; minimum 2.
- SETUP_CYCLES, 4: clock cycles data_pins is driven before host_ack rises on a host read; minimum 1.
- RX_DEPTH, 4: RX FIFO entries; power of two, minimum 2.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- chip_select  input  1  host direction: 1 = host writes (FPGA reads pins), 0 = host reads (FPGA drives pins).
- host_strobe  input  1  asynchronous host request; level-based.
- host_ack  output  1  registered acknowledge to host.
- data_pins  inout  8  shared parallel bus.
- tx_data  input  8  byte to send to host.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  byte accepted when tx_valid and tx_ready are both high.
- rx_data  output  8  FIFO head byte, first-word fall-through.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  pops head when rx_valid and rx_ready are both high.
- rx_level  output  clog2(RX_DEPTH)+1  FIFO occupancy.
- host_abort  output  1  one-cycle pulse: host dropped strobe before ack.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: host_ack=0, tx_ready=0, rx_valid=0, rx_level=0, host_abort=0.
  - Internal: FIFO pointers 0, state IDLE, pin driver released.
- Synchronisers:
  - chip_select and host_strobe pass through SYNC_STAGES flops; s_cs and s_stb are the last-stage outputs.
  - stb_rise is asserted when s_stb=1 and s_stb was 0 on the previous cycle.
- Tristate:
  - data_pins = drive_en && !chip_select ? tx_hold : 8'bZ.
  - The raw chip_select gates this combinationally, so the pins release immediately if the host flips direction.
- States:
  - IDLE: on stb_rise, latch dir=s_cs. dir=1 goes to WR_CAPTURE; dir=0 goes to RD_WAIT.
  - WR_CAPTURE:
    - If s_stb=0: pulse host_abort, go to IDLE.
    - Else if FIFO not full: push data_pins, go to WR_ACK. The sample is taken on the cycle WR_CAPTURE is occupied; the host holds data for the whole strobe-high interval.
    - Else (full): stall in WR_CAPTURE.
    - Full is evaluated before any same-cycle pop, so a push on a full FIFO waits at least one cycle even if rx_ready pops that cycle.
  - WR_ACK: host_ack=1; when s_stb=0, host_ack drops to 0 next cycle and the state returns to IDLE.
  - RD_WAIT:
    - tx_ready=1.
    - If s_stb=0 (checked first): pulse host_abort, go to IDLE, no byte consumed.
    - Else on tx handshake: tx_hold=tx_data, drive_en=1, counter=SETUP_CYCLES-1, go to RD_SETUP.
  - RD_SETUP: counter decrements each cycle; at 0 go to RD_ACK. host_ack rises exactly SETUP_CYCLES cycles after drive_en rises.
  - RD_ACK: host_ack=1, pins stay driven; when s_stb=0, host_ack=0, drive_en=0, go to IDLE (both deassert on the same edge).
- Handshake rules:
  - tx_ready is high only in RD_WAIT.
  - One strobe transfers exactly one byte.
  - A new transfer requires s_stb low in IDLE before the next rise.
  - host_ack never rises without s_stb high.
- FIFO:
  - Simultaneous push and pop when not full and not empty: rx_level unchanged.
  - Pointers wrap modulo RX_DEPTH.
  - rx_level saturates at RX_DEPTH by construction; there is no overflow.
  - Pop on empty is ignored.
- chip_select change mid-transaction: the latched dir governs the state machine; only the pin driver reacts to raw chip_select.
- host_abort is high for exactly one cycle per abort.

Test Plan:
- Host write 0xA5 with FIFO empty, rx_ready=0 -> host_ack rises; after strobe falls, host_ack falls; rx_valid=1, rx_data=0xA5, rx_level=1.
- Four host writes 0x01..0x04, then a fifth 0x05 with rx_ready=0 -> fifth stalls with host_ack=0. Pulse rx_ready once -> 0x01 popped, 0x05 captured, host_ack rises, FIFO order 0x02..0x05, rx_level=4.
- Host read with tx_valid=1, tx_data=0x3C -> tx_ready handshake; data_pins=0x3C; host_ack rises exactly 4 cycles later. Strobe low -> pins Z and host_ack=0 on the same edge.
- Host read with tx_valid=0, strobe dropped after 10 cycles -> host_abort pulses one cycle, tx_ready falls, no byte consumed, pins never driven.
- Host read in RD_ACK, chip_select driven to 1 -> data_pins Z immediately. Strobe low -> return to IDLE.
- Assert reset_n=0 in RD_SETUP -> host_ack=0, pins Z, rx_level=0 asynchronously. After release, a host write of 0x7E completes normally.
